vend_ctrl_multi: RTL

Parametrised multi-item vending controller, the next generation of the single-price coin FSM. It adds an N-item price table, per-item stock counters with sold-out detection, a credit ceiling, an inactivity timeout and a handshaked change/refund dispenser that pays out coin by coin. It sits between the debounced button/switch front end and the 7-segment display driver and coin-return actuator.

---
 rtl/vend_pkg.sv | 50 +++++
 rtl/vend_change_disp.sv | 58 +++++
 rtl/vend_ctrl_multi.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  // Coin-return actuator codes
  localparam logic [1:0] CHG_50 = 2'd0;
  localparam logic [1:0] CHG_25 = 2'd1;
  localparam logic [1:0] CHG_10 = 2'd2;
  localparam logic [1:0] CHG_5  = 2'd3;

  // Coin values in cents
  localparam logic [7:0] VAL_50 = 8'd50;
  localparam logic [7:0] VAL_25 = 8'd25;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;

  // Largest coin that still fits in the remaining amount
  function automatic logic [1:0] greedy_coin(input logic [31:0] amount);
    logic [1:0] code;
    if (amount >= 32'd50) begin
      code = CHG_50;
    end else if (amount >= 32'd25) begin
      code = CHG_25;
    end else if (amount >= 32'd10) begin
      code = CHG_10;
    end else begin
      code = CHG_5;
    end
    return code;
  endfunction

  // Cent value of a coin-return code
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] val;
    case (code)
      CHG_50:  val = VAL_50;
      CHG_25:  val = VAL_25;
      CHG_10:  val = VAL_10;
      default: val = VAL_5;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Change dispenser: holds the amount still owed and pays it out one coin
// at a time over a valid/ready handshake, largest coin first.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int VAL_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] load_val,
  input  logic             chg_ready,
  output logic             chg_valid,
  output logic [1:0]       chg_coin,
  output logic             done
);

  localparam logic [VAL_W-1:0] ZERO = {VAL_W{1'b0}};

  logic [VAL_W-1:0] change_r;
  logic [VAL_W-1:0] change_nx_s;
  logic             valid_r;
  logic [1:0]       coin_r;
  logic             done_r;

  // Remaining change after this cycle: a new load wins over a payout
  always_comb begin
    change_nx_s = change_r;
    if (load) begin
      change_nx_s = load_val;
    end else if (valid_r && chg_ready) begin
      change_nx_s = change_r - VAL_W'(coin_value(coin_r));
    end else begin
      change_nx_s = change_r;
    end
  end

  // Register the amount plus the coin offer derived from it, so the
  // offer is stable until accepted and the next coin follows one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_r <= ZERO;
      valid_r  <= 1'b0;
      coin_r   <= CHG_50;
      done_r   <= 1'b1;
    end else begin
      change_r <= change_nx_s;
      valid_r  <= (change_nx_s != ZERO);
      coin_r   <= greedy_coin(32'(change_nx_s));
      done_r   <= (change_nx_s == ZERO);
    end
  end

  assign chg_valid = valid_r;
  assign chg_coin  = coin_r;
  assign done      = done_r;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: price table, per-item stock, credit
// ceiling, inactivity refund and coin-by-coin change payout.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int N_ITEMS     = 4,
  parameter int VAL_W       = 12,
  parameter int STOCK_W     = 4,
  parameter int CREDIT_MAX  = 995,
  parameter int TIMEOUT_CYC = 500_000_000,
  localparam int SEL_W      = $clog2(N_ITEMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_ITEMS*VAL_W-1:0] price_tbl,
  input  logic                     coin_50,
  input  logic                     coin_25,
  input  logic                     coin_10,
  input  logic                     cancel,
  input  logic                     confirm,
  input  logic                     restock,
  input  logic                     chg_ready,
  output logic [VAL_W-1:0]         display_val,
  output logic                     led_purchase,
  output logic                     led_insuff,
  output logic                     led_soldout,
  output logic                     coin_reject,
  output logic                     vend_valid,
  output logic [SEL_W-1:0]         vend_item,
  output logic                     chg_valid,
  output logic [1:0]               chg_coin,
  output logic                     busy
);

  localparam int               TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO   = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
  localparam logic [VAL_W-1:0] VAL_ZERO   = {VAL_W{1'b0}};
  localparam logic [VAL_W-1:0] CREDIT_CAP = VAL_W'(CREDIT_MAX);
  localparam logic [STOCK_W-1:0] STOCK_FULL = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_ZERO = {STOCK_W{1'b0}};
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  vend_state_t      state_r, state_nx_s;
  logic [VAL_W-1:0] credit_r, credit_nx_s, credit_add_s;
  logic [VAL_W-1:0] pend_r, pend_nx_s;
  logic [SEL_W-1:0] item_r, item_nx_s, sel_q_r;
  logic [TMO_W-1:0] tmo_r, tmo_nx_s;
  logic [STOCK_W-1:0] stock_r [N_ITEMS];

  logic [VAL_W-1:0] display_r, display_nx_s;
  logic             insuff_r, insuff_nx_s;
  logic             soldout_r, soldout_nx_s;
  logic             purchase_r, purchase_nx_s;
  logic             reject_r, reject_nx_s;
  logic             vend_valid_r, vend_valid_nx_s;
  logic [SEL_W-1:0] vend_item_r, vend_item_nx_s;
  logic             busy_r;

  logic [VAL_W-1:0] price_sel_s, coin_val_s, coin_sum_s, load_val_s;
  logic             coin_any_s, coin_fit_s, coin_ok_s, pulse_any_s;
  logic             stock_zero_s, stock_dec_s, restock_s, load_s, chg_done_s;

  assign price_sel_s  = price_tbl[sel*VAL_W +: VAL_W];
  assign coin_any_s   = coin_50 | coin_25 | coin_10;
  assign pulse_any_s  = coin_any_s | cancel | confirm | restock;
  assign coin_sum_s   = credit_r + coin_val_s;
  assign coin_fit_s   = (coin_sum_s <= CREDIT_CAP);
  assign coin_ok_s    = coin_any_s & coin_fit_s;
  assign credit_add_s = coin_ok_s ? coin_sum_s : credit_r;
  assign stock_zero_s = (stock_r[sel] == STOCK_ZERO);

  // Highest-value coin wins when several pulse together
  always_comb begin
    coin_val_s = VAL_W'(VAL_10);
    if (coin_50) begin
      coin_val_s = VAL_W'(VAL_50);
    end else if (coin_25) begin
      coin_val_s = VAL_W'(VAL_25);
    end else begin
      coin_val_s = VAL_W'(VAL_10);
    end
  end

  // Controller next-state and next-output decode
  always_comb begin
    state_nx_s      = state_r;
    credit_nx_s     = credit_r;
    pend_nx_s       = pend_r;
    item_nx_s       = item_r;
    tmo_nx_s        = tmo_r;
    insuff_nx_s     = (sel != sel_q_r) ? 1'b0 : insuff_r;
    soldout_nx_s    = (sel != sel_q_r) ? 1'b0 : soldout_r;
    purchase_nx_s   = purchase_r;
    reject_nx_s     = 1'b0;
    vend_valid_nx_s = 1'b0;
    vend_item_nx_s  = vend_item_r;
    stock_dec_s     = 1'b0;
    restock_s       = 1'b0;
    load_s          = 1'b0;
    load_val_s      = credit_add_s;

    case (state_r)
      ST_IDLE: begin
        tmo_nx_s    = TMO_RELOAD;
        credit_nx_s = VAL_ZERO;
        reject_nx_s = coin_any_s & ~coin_fit_s;
        restock_s   = restock;
        if (coin_ok_s) begin
          credit_nx_s  = coin_sum_s;
          insuff_nx_s  = 1'b0;
          soldout_nx_s = 1'b0;
          state_nx_s   = ST_CREDIT;
        end else if (confirm) begin
          insuff_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_CREDIT: begin
        credit_nx_s = credit_add_s;
        reject_nx_s = coin_any_s & ~coin_fit_s;
        if (coin_ok_s) begin
          insuff_nx_s  = 1'b0;
          soldout_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_CREDIT;
        end
        if (pulse_any_s) begin
          tmo_nx_s = TMO_RELOAD;
        end else if (tmo_r != TMO_ZERO) begin
          tmo_nx_s = tmo_r - TMO_ONE;
        end else begin
          tmo_nx_s = tmo_r;
        end
        // Cancel beats confirm; a silent expired timer is an implicit cancel
        if (cancel || (!pulse_any_s && (tmo_r == TMO_ZERO))) begin
          insuff_nx_s  = 1'b0;
          soldout_nx_s = 1'b0;
          load_s       = 1'b1;
          load_val_s   = credit_add_s;
          credit_nx_s  = VAL_ZERO;
          state_nx_s   = ST_CHANGE;
        end else if (confirm) begin
          // Purchase decision uses the credit held before any same-cycle coin
          if (stock_zero_s) begin
            soldout_nx_s = 1'b1;
          end else if (credit_r < price_sel_s) begin
            insuff_nx_s = 1'b1;
          end else begin
            item_nx_s   = sel;
            pend_nx_s   = credit_add_s - price_sel_s;
            stock_dec_s = 1'b1;
            credit_nx_s = VAL_ZERO;
            state_nx_s  = ST_VEND;
          end
        end else begin
          state_nx_s = ST_CREDIT;
        end
      end

      ST_VEND: begin
        vend_valid_nx_s = 1'b1;
        vend_item_nx_s  = item_r;
        purchase_nx_s   = 1'b1;
        load_s          = 1'b1;
        load_val_s      = pend_r;
        pend_nx_s       = VAL_ZERO;
        state_nx_s      = ST_CHANGE;
      end

      ST_CHANGE: begin
        if (chg_done_s) begin
          purchase_nx_s = 1'b0;
          state_nx_s    = ST_IDLE;
        end else begin
          state_nx_s = ST_CHANGE;
        end
      end

      default: begin
        credit_nx_s = VAL_ZERO;
        state_nx_s  = ST_IDLE;
      end
    endcase

    display_nx_s = (state_nx_s == ST_IDLE) ? price_sel_s : credit_nx_s;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      credit_r     <= VAL_ZERO;
      pend_r       <= VAL_ZERO;
      item_r       <= {SEL_W{1'b0}};
      sel_q_r      <= {SEL_W{1'b0}};
      tmo_r        <= TMO_RELOAD;
      display_r    <= VAL_ZERO;
      insuff_r     <= 1'b0;
      soldout_r    <= 1'b0;
      purchase_r   <= 1'b0;
      reject_r     <= 1'b0;
      vend_valid_r <= 1'b0;
      vend_item_r  <= {SEL_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      credit_r     <= credit_nx_s;
      pend_r       <= pend_nx_s;
      item_r       <= item_nx_s;
      sel_q_r      <= sel;
      tmo_r        <= tmo_nx_s;
      display_r    <= display_nx_s;
      insuff_r     <= insuff_nx_s;
      soldout_r    <= soldout_nx_s;
      purchase_r   <= purchase_nx_s;
      reject_r     <= reject_nx_s;
      vend_valid_r <= vend_valid_nx_s;
      vend_item_r  <= vend_item_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
    end
  end

  // Per-item stock: restock refills the selected item, a vend takes one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_r[i] <= STOCK_FULL;
      end
    end else if (restock_s) begin
      stock_r[sel] <= STOCK_FULL;
    end else if (stock_dec_s) begin
      stock_r[sel] <= stock_r[sel] - STOCK_ONE;
    end
  end

  vend_change_disp #(.VAL_W(VAL_W)) u_change (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_val  (load_val_s),
    .chg_ready (chg_ready),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .done      (chg_done_s)
  );

  assign display_val  = display_r;
  assign led_purchase = purchase_r;
  assign led_insuff   = insuff_r;
  assign led_soldout  = soldout_r;
  assign coin_reject  = reject_r;
  assign vend_valid   = vend_valid_r;
  assign vend_item    = vend_item_r;
  assign busy         = busy_r;

endmodule
